// File: rtl/reconf_fir_tdm_mac.sv
// ---------------------------------------------------------------------------
// reconf_fir_tdm_mac
//   Reconfigurable transposed-form FIR filter that time-shares one
//   multiplier-accumulator across up to MAX_TAPS taps. Coefficients are held
//   in an internal RAM written through a chip-select/write-enable port while
//   the block is in coefficient-load mode. Partial sums z[] live in a second
//   internal RAM and are updated in place, one tap per clock.
//
// Optional feature macro: FIR_SAT_EN
//   defined   : shifted accumulator saturates to the OUT_W signed range
//   undefined : shifted accumulator wraps (keeps the low OUT_W bits)
//
// Ports
//   iClk_12M           clock, rising edge
//   iRst               asynchronous, active-high reset
//   iEnSample          one-cycle sample strobe, iFirIn valid with it
//   iFirIn             signed input sample (DATA_W)
//   iCoeffiUpdateFlag  high = coefficient load mode; falling edge latches N
//   iCsnRam, iWrnRam   active-low chip select / write enable
//   iAddrRam           coefficient index (tap 0 at address 0)
//   iWrDtRam           signed coefficient write data
//   iNumOfCoeff        active tap count, clamped to MAX_TAPS when latched
//   oFirOut            signed output, holds between valid pulses
//   oFirValid          one-cycle pulse marking a new oFirOut
//   oBusy              z[] clear after reset, or MAC sequence, in progress
//   oOverrun           sticky: a sample strobe was dropped
//   oDbgState          current FSM state (state_t encoding)
//
// Handshake: iEnSample has no back-pressure. A strobe is accepted only in
// ST_RUN without a pending load request; any other strobe is dropped and
// sets oOverrun. oFirValid is a single-cycle qualifier for oFirOut.
// ---------------------------------------------------------------------------
module reconf_fir_tdm_mac #(
  parameter int DATA_W    = 3,
  parameter int COEF_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int MAX_TAPS  = 64,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic                     iEnSample,
  input  logic signed [DATA_W-1:0] iFirIn,
  input  logic                     iCoeffiUpdateFlag,
  input  logic                     iCsnRam,
  input  logic                     iWrnRam,
  input  logic [ADDR_W-1:0]        iAddrRam,
  input  logic signed [COEF_W-1:0] iWrDtRam,
  input  logic [ADDR_W:0]          iNumOfCoeff,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oFirValid,
  output logic                     oBusy,
  output logic                     oOverrun,
  output logic [1:0]               oDbgState
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int EXT_W  = ACC_W + OUT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_MAC  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          clr_q, clr_d;
  logic [ADDR_W-1:0]         k_q, k_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]          n_q, n_d;
  logic                      pend_q, pend_d;
  logic signed [OUT_W-1:0]   out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      ovr_q, ovr_d;

  logic signed [COEF_W-1:0]  coef_mem [MAX_TAPS];
  logic signed [ACC_W-1:0]   z_mem    [MAX_TAPS];

  logic                      coef_we;
  logic                      z_we;
  logic [ADDR_W-1:0]         z_waddr;
  logic signed [ACC_W-1:0]   z_wdata;
  logic                      z_tail_we;

  logic                      clr_done;
  logic                      k_last;
  logic signed [COEF_W-1:0]  h_k;
  logic signed [ACC_W-1:0]   z_k;
  logic signed [PROD_W-1:0]  x_ext, h_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, sum;

  // Datapath: one full-precision product and one accumulate per cycle.
  assign h_k      = coef_mem[k_q];
  assign z_k      = z_mem[k_q];
  assign x_ext    = {{COEF_W{x_q[DATA_W-1]}}, x_q};
  assign h_ext    = {{DATA_W{h_k[COEF_W-1]}}, h_k};
  assign prod     = x_ext * h_ext;
  assign prod_ext = {{ADDR_W{prod[PROD_W-1]}}, prod};
  assign sum      = prod_ext + z_k;

  assign clr_done = (clr_q == CNT_W'(MAX_TAPS));
  assign k_last   = ({1'b0, k_q} == (n_q - CNT_W'(1)));

  // Scale the accumulator and fit it into OUT_W bits.
  function automatic logic signed [OUT_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] wide;
    logic signed [EXT_W-1:0] sh;
`ifdef FIR_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(ACC_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(ACC_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif
    wide = {{OUT_W{a[ACC_W-1]}}, a};
    sh   = wide >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
    if (sh > SAT_MAX) begin
      sh = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      sh = SAT_MIN;
    end
`endif
    return OUT_W'(sh);
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    k_d       = k_q;
    x_d       = x_q;
    n_d       = n_q;
    pend_d    = 1'b0;
    out_d     = out_q;
    valid_d   = 1'b0;
    ovr_d     = ovr_q;
    coef_we   = 1'b0;
    z_we      = 1'b0;
    z_waddr   = '0;
    z_wdata   = '0;
    z_tail_we = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        // z[] is swept to zero in both states; the sweep restarts on every
        // load entry so a shortened load still ends with a clean z[].
        if (!clr_done) begin
          z_we    = 1'b1;
          z_waddr = clr_q[ADDR_W-1:0];
          clr_d   = clr_q + CNT_W'(1);
        end
        if (iEnSample) begin
          ovr_d = 1'b1;
        end
        if (state_q == ST_IDLE) begin
          if (iCoeffiUpdateFlag) begin
            state_d = ST_LOAD;
            ovr_d   = 1'b0;
            clr_d   = '0;
          end else if (clr_done) begin
            state_d = ST_RUN;
          end
        end else begin
          coef_we = !iCsnRam && !iWrnRam && ({1'b0, iAddrRam} < CNT_W'(MAX_TAPS));
          // Flag is known to have been high last cycle, so low here is the
          // falling edge.
          if (!iCoeffiUpdateFlag) begin
            n_d     = (iNumOfCoeff > CNT_W'(MAX_TAPS)) ? CNT_W'(MAX_TAPS) : iNumOfCoeff;
            state_d = clr_done ? ST_RUN : ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        if (iCoeffiUpdateFlag) begin
          state_d = ST_LOAD;
          ovr_d   = 1'b0;
          clr_d   = '0;
        end else begin
          // N=0: each accepted sample produces a zero one cycle later.
          if (pend_q) begin
            out_d   = '0;
            valid_d = 1'b1;
          end
          if (iEnSample) begin
            x_d = iFirIn;
            k_d = '0;
            if (n_q == '0) begin
              pend_d = 1'b1;
            end else begin
              state_d = ST_MAC;
            end
          end
        end
      end

      ST_MAC: begin
        if (iCoeffiUpdateFlag) begin
          state_d = ST_LOAD;
          ovr_d   = 1'b0;
          clr_d   = '0;
        end else begin
          if (iEnSample) begin
            ovr_d = 1'b1;
          end
          if (k_q == '0) begin
            out_d   = reduce_acc(sum);
            valid_d = 1'b1;
          end else begin
            z_we    = 1'b1;
            z_waddr = k_q - ADDR_W'(1);
            z_wdata = sum;
          end
          if (k_last) begin
            z_tail_we = 1'b1;
            state_d   = ST_RUN;
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_MAC) ||
             ((state_d == ST_IDLE) && (clr_d != CNT_W'(MAX_TAPS)));
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      clr_q   <= '0;
      k_q     <= '0;
      x_q     <= '0;
      n_q     <= '0;
      pend_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      k_q     <= k_d;
      x_q     <= x_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // RAM arrays carry no reset; z[] is cleared by the sweep above.
  // z[k] is read combinationally in the same cycle its predecessor slot
  // z[k-1] is written, so every slot is consumed before it is replaced.
  always_ff @(posedge iClk_12M) begin
    if (coef_we) begin
      coef_mem[iAddrRam] <= iWrDtRam;
    end
    if (z_we) begin
      z_mem[z_waddr] <= z_wdata;
    end
    if (z_tail_we) begin
      z_mem[k_q] <= '0;
    end
  end

  assign oFirOut   = out_q;
  assign oFirValid = valid_q;
  assign oBusy     = busy_q;
  assign oOverrun  = ovr_q;
  assign oDbgState = state_q;

endmodule
